// File: rtl/uart_echo_buffer.sv
// Byte FIFO and transmit sequencer between the UART receiver and transmitter.
// Optional UART_ECHO_BUFFER_DROP_CNT_EN adds a saturating count of bytes dropped while full.
module uart_echo_buffer #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Rx_DV,
  input  logic [7:0]            i_Rx_Byte,
  input  logic                  i_Tx_Active,
  input  logic                  i_Tx_Done,
  output logic                  o_Tx_DV,
  output logic [7:0]            o_Tx_Byte,
  output logic [DEPTH_LOG2:0]   o_Count,
  output logic                  o_Full,
  output logic                  o_Empty
`ifdef UART_ECHO_BUFFER_DROP_CNT_EN
  ,
  output logic [7:0]            o_Drop_Count
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  push;
  logic                  pop;

  // Fullness uses the registered count, so a push while full is lost even if a pop happens too.
  assign push = i_Rx_DV && !o_Full;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!o_Empty && !i_Tx_Active) begin
          pop        = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (i_Tx_Done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = o_Count;
    case ({push, pop})
      2'b10:   count_next = o_Count + 1'b1;
      2'b01:   count_next = o_Count - 1'b1;
      default: count_next = o_Count;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_Count   <= '0;
      o_Empty   <= 1'b1;
      o_Full    <= 1'b0;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= '0;
    end else begin
      o_Count <= count_next;
      o_Empty <= (count_next == '0);
      o_Full  <= (count_next == FULL_COUNT);
      o_Tx_DV <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        o_Tx_Byte <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem[wr_ptr] <= i_Rx_Byte;
    end
  end

`ifdef UART_ECHO_BUFFER_DROP_CNT_EN
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_Drop_Count <= '0;
    end else if (i_Rx_DV && o_Full && (o_Drop_Count != 8'hFF)) begin
      o_Drop_Count <= o_Drop_Count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Self-checking bench for uart_echo_buffer: cycle table plus scoreboarded echo sequences.
// Set UART_ECHO_BUFFER_DROP_CNT_EN to also exercise the drop counter.
module tb_uart_echo_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_active;
  logic       tx_done;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic [4:0] count;
  logic       full;
  logic       empty;
`ifdef UART_ECHO_BUFFER_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  logic hold_active = 1'b0;
  logic man_done    = 1'b0;
  logic model_en    = 1'b0;
  logic model_active = 1'b0;
  logic model_done  = 1'b0;
  int   model_hold  = 20;
  int   model_cnt   = 0;
  logic act_at_edge = 1'b0;
  logic prev_dv     = 1'b0;
  int   launches    = 0;
  int   tests       = 0;
  int   fails       = 0;
  logic [7:0] sb [$];

  assign tx_active = model_active | hold_active;
  assign tx_done   = model_done | man_done;

  always #5 clk = ~clk;

  uart_echo_buffer #(.DEPTH_LOG2(4)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Rx_DV     (rx_dv),
    .i_Rx_Byte   (rx_byte),
    .i_Tx_Active (tx_active),
    .i_Tx_Done   (tx_done),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
    .o_Count     (count),
    .o_Full      (full),
    .o_Empty     (empty)
`ifdef UART_ECHO_BUFFER_DROP_CNT_EN
    ,
    .o_Drop_Count(drop_count)
`endif
  );

  typedef struct {
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       act;
    logic       done;
    int         exp_count;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_dv;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accepted);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    if (accepted) sb.push_back(b);
  endtask

  task automatic rx_stop();
    @(negedge clk);
    rx_dv = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while ((sb.size() != 0 || model_active || model_done || !empty) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < max_cycles), 32'd1);
    check("drain_count", 32'(count), 32'd0);
  endtask

  initial begin
    int l0;

    fork
      forever begin
        @(posedge clk);
        act_at_edge = tx_active;
      end
      forever begin
        @(negedge clk);
        if (model_done) model_done = 1'b0;
        if (model_active) begin
          if (model_cnt > 1) model_cnt--;
          else begin
            model_active = 1'b0;
            model_done   = 1'b1;
          end
        end
        if (tx_dv) begin
          launches++;
          check("dv_single_cycle", 32'(prev_dv), 32'd0);
          check("active_at_launch", 32'(act_at_edge), 32'd0);
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_launch: got byte %0h expected no strobe at %0t", tx_byte, $time);
          end else begin
            check("echo_byte", 32'(tx_byte), 32'(sb.pop_front()));
          end
          if (model_en) begin
            model_active = 1'b1;
            model_cnt    = model_hold;
          end
        end
        prev_dv = tx_dv;
      end
    join_none

    vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h22, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h33, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0};

    // Reset values while reset is held
    repeat (3) @(negedge clk);
    check("rst_dv", 32'(tx_dv), 32'd0);
    check("rst_byte", 32'(tx_byte), 32'h00);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
`ifdef UART_ECHO_BUFFER_DROP_CNT_EN
    check("rst_drop", 32'(drop_count), 32'd0);
`endif
    rst = 1'b0;

    // Single byte latency and simultaneous push/pop, cycle by cycle
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rx_dv       = vecs[i].rx_dv;
      rx_byte     = vecs[i].rx_byte;
      hold_active = vecs[i].act;
      man_done    = vecs[i].done;
      if (vecs[i].rx_dv) sb.push_back(vecs[i].rx_byte);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
      check($sformatf("vec%0d_dv", i), 32'(tx_dv), 32'(vecs[i].exp_dv));
    end
    @(negedge clk);
    rx_dv = 1'b0; hold_active = 1'b0; man_done = 1'b0;
    check("table_sb_empty", 32'(sb.size()), 32'd0);

    // Burst ordering with a slow transmitter
    model_en = 1'b1;
    model_hold = 20;
    l0 = launches;
    for (int i = 0; i < 4; i++) push_byte(8'(i), 1'b1);
    rx_stop();
    wait_drain(200);
    check("burst_launches", 32'(launches - l0), 32'd4);

    // Overflow while the transmitter is held busy
    model_hold = 4;
    @(negedge clk);
    hold_active = 1'b1;
    for (int i = 0; i < 18; i++) push_byte(8'(8'h10 + i), i < 16);
    rx_stop();
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_empty", 32'(empty), 32'd0);
`ifdef UART_ECHO_BUFFER_DROP_CNT_EN
    check("ovf_drop", 32'(drop_count), 32'd2);
`endif
    l0 = launches;
    hold_active = 1'b0;
    wait_drain(400);
    check("ovf_launches", 32'(launches - l0), 32'd16);
    check("ovf_full_after", 32'(full), 32'd0);

    // Pointer wrap: 40 bytes pushed and drained in pairs
    model_hold = 3;
    l0 = launches;
    for (int p = 0; p < 20; p++) begin
      push_byte(8'(2 * p), 1'b1);
      push_byte(8'(2 * p + 1), 1'b1);
      rx_stop();
      wait_drain(60);
    end
    check("wrap_launches", 32'(launches - l0), 32'd40);

    // Reset while BUSY with five bytes queued
    model_hold = 20;
    for (int i = 0; i < 6; i++) push_byte(8'(8'h50 + i), 1'b1);
    rx_stop();
    check("pre_rst_count", 32'(count), 32'd5);
    check("pre_rst_busy", 32'(model_active), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_dv", 32'(tx_dv), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    l0 = launches;
    repeat (30) @(negedge clk);
    check("post_rst_no_launch", 32'(launches - l0), 32'd0);
    check("post_rst_count", 32'(count), 32'd0);
    check("post_rst_model_idle", 32'(model_active), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_echo_buffer.md
# uart_echo_buffer

Byte FIFO plus transmit sequencer between the UART receiver and the UART transmitter in the `uart_echo` design. It captures every byte strobed out of the receiver and replays the bytes in order to the transmitter, one at a time, honouring the transmitter's busy/done handshake. Short receive bursts therefore echo without loss while the transmitter is still shifting out an earlier byte.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 bytes (16 by default).

Ports:
- `i_Clock`  in  1  system clock (12 MHz on the board).
- `i_Reset`  in  1  reset; one clock, reset is asynchronous and active-high.
- `i_Rx_DV`  in  1  single-cycle strobe from the receiver: `i_Rx_Byte` is valid.
- `i_Rx_Byte`  in  8  received byte.
- `i_Tx_Active`  in  1  transmitter busy shifting a byte.
- `i_Tx_Done`  in  1  single-cycle pulse from the transmitter at the end of the stop bit.
- `o_Tx_DV`  out  1  single-cycle start strobe to the transmitter.
- `o_Tx_Byte`  out  8  byte to transmit; held stable from `o_Tx_DV` until the next launch.
- `o_Count`  out  DEPTH_LOG2+1  bytes currently stored.
- `o_Full`  out  1  `o_Count` == 2^DEPTH_LOG2.
- `o_Empty`  out  1  `o_Count` == 0.

## Operation
- Storage: 2^DEPTH_LOG2 x 8 memory, write pointer `wr_ptr` and read pointer `rd_ptr` (DEPTH_LOG2 bits each), and a separate count register.
  - Both pointers wrap modulo depth.
- Push: on `i_Rx_DV`=1 with `o_Full`=0, write `mem[wr_ptr]` and increment `wr_ptr`.
  - Push with `o_Full`=1: the byte is discarded and pointers are unchanged.
  - Fullness is judged on the pre-edge count, so a push while full is dropped even if a pop occurs in the same cycle.
- Sequencer FSM, two states:
  - IDLE: if `o_Empty`=0 and `i_Tx_Active`=0, then `o_Tx_Byte` <= `mem[rd_ptr]`, `o_Tx_DV` <= 1, `rd_ptr`++, and go to BUSY. Otherwise stay in IDLE.
  - BUSY: `o_Tx_DV` <= 0. Wait for `i_Tx_Done`=1, then go to IDLE.
  - `i_Tx_Done` seen while in IDLE is ignored.
- Count update: +1 on accepted push only; -1 on pop only; unchanged when both happen in the same cycle.
- Empty FIFO: no pop, `o_Tx_DV` stays 0.

## Timing
- Reset values: `o_Tx_DV`=0, `o_Tx_Byte`=8'h00, `o_Count`=0, `o_Empty`=1, `o_Full`=0.
  - Pointers are 0 and the FSM is in IDLE.
  - Memory contents are not reset.
- Reset asserted mid-operation clears all of the above immediately. Any byte still in the transmitter is abandoned; its later `i_Tx_Done` is ignored.
- Latency: with `i_Rx_DV` in cycle N into an empty, idle buffer (`i_Tx_Active`=0), `o_Tx_DV` is high in cycle N+2.
- `o_Tx_DV` is high for exactly one cycle per launch.
- Minimum spacing between launches is one cycle after `i_Tx_Done`, and only if `i_Tx_Active` is already low then.
- `o_Count`, `o_Full`, and `o_Empty` are registered and reflect the state after the last edge.
- Ordering: output bytes are strictly FIFO order of accepted pushes.

## Configuration
- `UART_ECHO_BUFFER_DROP_CNT_EN` defined: adds output port `o_Drop_Count` (out, 8 bits).
  - Increments on every push rejected because the buffer is full.
  - Saturates at 8'hFF and is cleared only by `i_Reset`.
- Undefined: the port and counter are absent, and dropped bytes are silent.

## Test plan
- Single byte: reset, then `i_Rx_DV` with 8'h00 in cycle N.
  - Expect `o_Tx_DV`=1 in cycle N+2 with `o_Tx_Byte`=8'h00.
  - Expect `o_Count` 0->1->0.
- Burst ordering: push 8'h00, 8'h01, 8'h02, 8'h03 on consecutive cycles. The transmitter model holds `i_Tx_Active` for 20 cycles, then pulses `i_Tx_Done`.
  - Expect four `o_Tx_DV` strobes carrying 00, 01, 02, 03 in that order.
  - Expect no strobe while `i_Tx_Active`=1.
- Overflow: hold `i_Tx_Active`=1 and push 18 bytes 8'h10..8'h21.
  - Expect `o_Full`=1 and `o_Count`=16.
  - After release, expect 8'h10..8'h1F to be echoed.
  - With the macro defined, expect `o_Drop_Count`=2.
- Simultaneous push/pop: with `o_Count`=3, push 8'hA5 in the same cycle as an IDLE launch.
  - Expect `o_Count` to remain 3.
  - Expect 8'hA5 to be echoed last.
- Pointer wrap: push and drain 40 bytes 8'h00..8'h27 in pairs.
  - Expect exact in-order output across multiple pointer wraps.
- Reset mid-operation: with 5 bytes queued and the FSM in BUSY, pulse `i_Reset`.
  - Expect `o_Count`=0, `o_Empty`=1, `o_Tx_DV`=0.
  - A later `i_Tx_Done` must produce no strobe.
